// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one Data_Memory line port between the instruction cache (port 0)
// and dcache_top (port 1). One line transaction at a time, round-robin on
// ties, with a watchdog that abandons a transaction the memory never acks.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  r0_addr_i,
  input  logic [255:0] r0_data_i,
  input  logic         r0_enable_i,
  input  logic         r0_write_i,
  output logic         r0_ack_o,
  output logic [255:0] r0_data_o,
  input  logic [31:0]  r1_addr_i,
  input  logic [255:0] r1_data_i,
  input  logic         r1_enable_i,
  input  logic         r1_write_i,
  output logic         r1_ack_o,
  output logic [255:0] r1_data_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i,
  output logic         grant_o,
  output logic         busy_o,
  output logic         err_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;

  logic             busy;
  logic             selEnable;
  logic             selWrite;
  logic [31:0]      selAddr;
  logic [255:0]     selData;

  // Route the granted requester's fields toward the memory side
  always_comb begin
    selEnable = grant_q ? r1_enable_i : r0_enable_i;
    selWrite  = grant_q ? r1_write_i  : r0_write_i;
    selAddr   = grant_q ? r1_addr_i   : r0_addr_i;
    selData   = grant_q ? r1_data_i   : r0_data_i;
  end

  // Next-state logic: grant decision in IDLE, completion/abort/timeout in BUSY
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (r0_enable_i && r1_enable_i) begin
          grant_d = ~last_q;
          state_d = BUSY;
        end else if (r0_enable_i) begin
          grant_d = 1'b0;
          state_d = BUSY;
        end else if (r1_enable_i) begin
          grant_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          last_d  = grant_q;
          wdog_d  = '0;
          state_d = RELEASE;
        end else if (!selEnable) begin
          wdog_d  = '0;
          state_d = RELEASE;
        end else if (wdog_q == WDOG_LAST) begin
          err_d   = 1'b1;
          wdog_d  = '0;
          state_d = RELEASE;
        end else begin
          wdog_d  = wdog_q + 1'b1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last starts at 1 so port 0 wins the first tie
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Outputs: memory side only driven in BUSY, acks pass through combinationally
  always_comb begin
    busy         = (state_q == BUSY);
    busy_o       = busy;
    grant_o      = grant_q;
    err_o        = err_q;
    mem_enable_o = busy ? selEnable : 1'b0;
    mem_write_o  = busy ? selWrite  : 1'b0;
    mem_addr_o   = busy ? selAddr   : 32'd0;
    mem_data_o   = busy ? selData   : 256'd0;
    r0_ack_o     = busy && mem_ack_i && !grant_q;
    r1_ack_o     = busy && mem_ack_i && grant_q;
    r0_data_o    = r0_ack_o ? mem_data_i : 256'd0;
    r1_data_o    = r1_ack_o ? mem_data_i : 256'd0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed scenarios for the two-port memory arbiter: single read, tie
// breaking, alternation, writes, watchdog timeout and reset mid-transaction.
module tb_mem_port_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  r0_addr_i, r1_addr_i;
  logic [255:0] r0_data_i, r1_data_i;
  logic         r0_enable_i, r1_enable_i;
  logic         r0_write_i, r1_write_i;
  logic         r0_ack_o, r1_ack_o;
  logic [255:0] r0_data_o, r1_data_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;
  logic         grant_o, busy_o, err_o;

  int testsRun = 0;
  int testsFailed = 0;

  mem_port_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i), .r0_enable_i(r0_enable_i),
    .r0_write_i(r0_write_i), .r0_ack_o(r0_ack_o), .r0_data_o(r0_data_o),
    .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i), .r1_enable_i(r1_enable_i),
    .r1_write_i(r1_write_i), .r1_ack_o(r1_ack_o), .r1_data_o(r1_data_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    r0_addr_i = '0; r0_data_i = '0; r0_enable_i = 1'b0; r0_write_i = 1'b0;
    r1_addr_i = '0; r1_data_i = '0; r1_enable_i = 1'b0; r1_write_i = 1'b0;
    mem_ack_i = 1'b0; mem_data_i = '0;
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    clear_inputs();
    tick();
    rst_i = 1'b0;
  endtask

  // Entered in the first BUSY cycle; memory acks on cycle lat, then the
  // served requester drops its enable and the arbiter sits in RELEASE
  task automatic serve(input int lat, input logic expGrant, input logic [31:0] addr,
                       input logic wr, input logic [255:0] wdata,
                       input logic [255:0] line, input string name);
    for (int i = 1; i <= lat; i++) begin
      testsRun++;
      if ({busy_o, grant_o, mem_enable_o} !== {1'b1, expGrant, 1'b1}) begin
        testsFailed++;
        $display("[TB] FAIL %s busy/grant/en cyc %0d: got %b%b%b expected 1%b1",
                 name, i, busy_o, grant_o, mem_enable_o, expGrant);
      end
      testsRun++;
      if ({mem_addr_o, mem_write_o, mem_data_o} !== {addr, wr, wdata}) begin
        testsFailed++;
        $display("[TB] FAIL %s mem fields cyc %0d: got %h/%b/%h expected %h/%b/%h",
                 name, i, mem_addr_o, mem_write_o, mem_data_o, addr, wr, wdata);
      end
      if (i == lat) begin
        mem_ack_i = 1'b1;
        mem_data_i = line;
        #1;
        testsRun++;
        if ({r0_ack_o, r1_ack_o} !== (expGrant ? 2'b01 : 2'b10)) begin
          testsFailed++;
          $display("[TB] FAIL %s ack: got r0=%b r1=%b expected port %b only",
                   name, r0_ack_o, r1_ack_o, expGrant);
        end
        testsRun++;
        if ((expGrant ? r1_data_o : r0_data_o) !== line) begin
          testsFailed++;
          $display("[TB] FAIL %s rdata: got %h expected %h", name,
                   expGrant ? r1_data_o : r0_data_o, line);
        end
      end else begin
        testsRun++;
        if ({r0_ack_o, r1_ack_o} !== 2'b00) begin
          testsFailed++;
          $display("[TB] FAIL %s early ack cyc %0d: got %b%b expected 00",
                   name, i, r0_ack_o, r1_ack_o);
        end
        tick();
      end
    end
    tick();
    if (expGrant) r1_enable_i = 1'b0; else r0_enable_i = 1'b0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    #1;
    testsRun++;
    if ({busy_o, mem_enable_o, r0_ack_o, r1_ack_o} !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL %s release: got busy=%b en=%b acks=%b%b expected all 0",
               name, busy_o, mem_enable_o, r0_ack_o, r1_ack_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    clear_inputs();
    tick();
    testsRun++;
    if ({busy_o, grant_o, err_o, mem_enable_o, mem_write_o, r0_ack_o, r1_ack_o} !== 7'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs: got %b%b%b%b%b%b%b expected 0000000", busy_o,
               grant_o, err_o, mem_enable_o, mem_write_o, r0_ack_o, r1_ack_o);
    end
    testsRun++;
    if ({mem_addr_o, mem_data_o} !== 288'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset mem bus: got %h/%h expected 0", mem_addr_o, mem_data_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    logic [255:0] lineL;
    lineL = {8{32'hCAFE_0040}};
    r1_addr_i = 32'h40;
    r1_write_i = 1'b0;
    r1_data_i = {8{32'h1111_2222}};
    r1_enable_i = 1'b1;
    #1;
    testsRun++;
    if (mem_enable_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL read idle enable: got %b expected 0", mem_enable_o);
    end
    tick();
    serve(10, 1'b1, 32'h40, 1'b0, {8{32'h1111_2222}}, lineL, "read");
    mem_ack_i = 1'b1;
    mem_data_i = lineL;
    #1;
    testsRun++;
    if ({r0_ack_o, r1_ack_o, r1_data_o} !== {2'b00, 256'd0}) begin
      testsFailed++;
      $display("[TB] FAIL stray ack in release: got %b%b %h expected 00 0",
               r0_ack_o, r1_ack_o, r1_data_o);
    end
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    tick();
    testsRun++;
    if (busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL read back to idle: got busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    r0_addr_i = 32'h100; r1_addr_i = 32'h200;
    r0_enable_i = 1'b1; r1_enable_i = 1'b1;
    tick();
    serve(2, 1'b0, 32'h100, 1'b0, '0, {8{32'hA0A0_0001}}, "tie first");
    tick();
    testsRun++;
    if (busy_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL tie idle gap: got busy=%b expected 0", busy_o);
    end
    tick();
    serve(2, 1'b1, 32'h200, 1'b0, '0, {8{32'hB0B0_0002}}, "tie second");
    r0_enable_i = 1'b1; r1_enable_i = 1'b1;
    tick();
    tick();
    serve(1, 1'b0, 32'h100, 1'b0, '0, {8{32'hA0A0_0003}}, "tie again");
    tick();
    tick();
    serve(1, 1'b1, 32'h200, 1'b0, '0, {8{32'hB0B0_0004}}, "tie drain");
    tick();
  endtask

  task automatic test_fairness();
    logic expGrant;
    pulse_reset();
    r0_addr_i = 32'h300; r1_addr_i = 32'h400;
    r0_enable_i = 1'b1; r1_enable_i = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      expGrant = k[0];
      serve(1, expGrant, expGrant ? 32'h400 : 32'h300, 1'b0, '0,
            {8{k[31:0]}}, "alternate");
      tick();
      if (k < 5) begin
        if (expGrant) r1_enable_i = 1'b1; else r0_enable_i = 1'b1;
        tick();
      end
    end
    r0_enable_i = 1'b0; r1_enable_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write();
    logic [255:0] dataD;
    dataD = {4{64'hDEAD_BEEF_0123_4567}};
    r1_addr_i = 32'h80;
    r1_data_i = dataD;
    r1_write_i = 1'b1;
    r1_enable_i = 1'b1;
    tick();
    serve(3, 1'b1, 32'h80, 1'b1, dataD, '0, "write");
    r1_write_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    r0_addr_i = 32'h500;
    r0_write_i = 1'b0;
    r0_enable_i = 1'b1;
    tick();
    for (int i = 1; i <= 64; i++) begin
      testsRun++;
      if ({busy_o, err_o, r0_ack_o, r1_ack_o} !== 4'b1000) begin
        testsFailed++;
        $display("[TB] FAIL timeout busy cyc %0d: got busy=%b err=%b acks=%b%b expected 1 0 00",
                 i, busy_o, err_o, r0_ack_o, r1_ack_o);
      end
      tick();
    end
    testsRun++;
    if ({busy_o, err_o} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL timeout release: got busy=%b err=%b expected 0 1", busy_o, err_o);
    end
    r0_enable_i = 1'b0;
    tick();
    testsRun++;
    if ({busy_o, err_o} !== 2'b01) begin
      testsFailed++;
      $display("[TB] FAIL timeout idle: got busy=%b err=%b expected 0 1", busy_o, err_o);
    end
    r1_addr_i = 32'h600;
    r1_write_i = 1'b0;
    r1_enable_i = 1'b1;
    tick();
    serve(2, 1'b1, 32'h600, 1'b0, r1_data_i, {8{32'h600D_600D}}, "after timeout");
    testsRun++;
    if (err_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL err sticky: got %b expected 1", err_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    r0_addr_i = 32'h700;
    r0_write_i = 1'b0;
    r0_enable_i = 1'b1;
    tick();
    serve(1, 1'b0, 32'h700, 1'b0, r0_data_i, {8{32'h7777_0000}}, "pre reset");
    tick();
    r1_addr_i = 32'h800;
    r1_enable_i = 1'b1;
    tick();
    for (int i = 1; i < 5; i++) tick();
    testsRun++;
    if ({busy_o, mem_enable_o} !== 2'b11) begin
      testsFailed++;
      $display("[TB] FAIL mid busy: got busy=%b en=%b expected 1 1", busy_o, mem_enable_o);
    end
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    #1;
    testsRun++;
    if ({busy_o, mem_enable_o, r0_ack_o, r1_ack_o, err_o} !== 5'b00000) begin
      testsFailed++;
      $display("[TB] FAIL async reset: got busy=%b en=%b acks=%b%b err=%b expected all 0",
               busy_o, mem_enable_o, r0_ack_o, r1_ack_o, err_o);
    end
    clear_inputs();
    tick();
    rst_i = 1'b0;
    r0_addr_i = 32'h900; r1_addr_i = 32'hA00;
    r0_enable_i = 1'b1; r1_enable_i = 1'b1;
    tick();
    testsRun++;
    if ({busy_o, grant_o} !== 2'b10) begin
      testsFailed++;
      $display("[TB] FAIL tie after reset: got busy=%b grant=%b expected 1 0", busy_o, grant_o);
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_fairness();
    test_write();
    test_timeout();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
